// File: rtl/controlador_pkg.sv
//==============================================================================
// controlador_pkg : FSM state type and load opcodes shared by the controller.
// Revision: 1.0
//==============================================================================
`default_nettype none

package controlador_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EXEC = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] OP_LOAD_A = 4'b0000;
    localparam logic [3:0] OP_LOAD_B = 4'b0001;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LOAD_A) || (op == OP_LOAD_B);
    endfunction

endpackage

`default_nettype wire

// File: rtl/controlador_seq_if.sv
//==============================================================================
// controlador_seq_if : instruction handshake, register-load and ULA bus.
// Revision: 1.0
//==============================================================================
`default_nettype none

interface controlador_seq_if #(
    parameter int DATA_W = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [3:0]        instr_op;
    logic [DATA_W-1:0] instr_data;
    logic [DATA_W-1:0] dado;
    logic              load_a;
    logic              load_b;
    logic [3:0]        ula_op;
    logic              ula_start;
    logic              ula_done;
    logic              busy;
    logic [7:0]        op_count;
    logic              erro;

    modport slave (
        input  instr_valid, instr_op, instr_data, ula_done,
        output instr_ready, dado, load_a, load_b, ula_op, ula_start,
               busy, op_count, erro
    );

    modport master (
        output instr_valid, instr_op, instr_data, ula_done,
        input  instr_ready, dado, load_a, load_b, ula_op, ula_start,
               busy, op_count, erro
    );
endinterface

`default_nettype wire

// File: rtl/controlador_timeout.sv
//==============================================================================
// controlador_timeout : counts WAIT cycles, flags the last one before abort.
// Revision: 1.0
//==============================================================================
`default_nettype none

module controlador_timeout #(
    parameter int TIMEOUT = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic enable,
    output logic      expired
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] r_cnt;

    // expired is high during the TIMEOUT-th consecutive enabled cycle
    assign expired = enable && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!enable) begin
            r_cnt <= '0;
        end else if (!expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: rtl/controlador_seq.sv
//==============================================================================
// controlador_seq : sequencer issuing register loads and ULA operations.
// Optional ULA timeout abort enabled by macro ULA_TIMEOUT_EN.   Revision: 1.0
//==============================================================================
`default_nettype none

module controlador_seq
    import controlador_pkg::*;
#(
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 8
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    controlador_seq_if.slave bus
);
    state_t            r_state, w_next;
    logic              r_ready, w_ready;
    logic              r_busy, w_busy;
    logic              r_load_a, w_load_a;
    logic              r_load_b, w_load_b;
    logic              r_ula_start, w_ula_start;
    logic [3:0]        r_ula_op, w_ula_op;
    logic [DATA_W-1:0] r_dado, w_dado;
    logic [7:0]        r_count, w_count;
    logic              w_xfer, w_inc, w_expired, w_in_wait;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("controlador_seq: TIMEOUT must be at least 1");
    end

    assign w_in_wait = (r_state == ST_WAIT);

    always_comb begin
        w_next = r_state;
        w_inc  = 1'b0;
        // ready is only high in IDLE, so a transfer implies IDLE
        w_xfer = r_ready && bus.instr_valid;
        case (r_state)
            ST_IDLE: if (w_xfer) w_next = is_load(bus.instr_op) ? ST_LOAD : ST_EXEC;
            ST_LOAD: w_next = ST_IDLE;
            ST_EXEC: w_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.ula_done) begin
                    w_next = ST_IDLE;
                    w_inc  = 1'b1;
                end else if (w_expired) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase

        // Outputs are computed for the next state and registered alongside it
        w_load_a    = w_xfer && (bus.instr_op == OP_LOAD_A);
        w_load_b    = w_xfer && (bus.instr_op == OP_LOAD_B);
        w_dado      = (w_load_a || w_load_b) ? bus.instr_data : r_dado;
        w_ula_start = w_xfer && !is_load(bus.instr_op);
        w_ula_op    = w_ula_start ? bus.instr_op :
                      ((w_next == ST_WAIT) ? r_ula_op : 4'b0000);
        w_ready     = (w_next == ST_IDLE);
        w_busy      = (w_next != ST_IDLE);
        w_count     = r_count + {7'd0, w_inc};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
            r_load_a    <= 1'b0;
            r_load_b    <= 1'b0;
            r_ula_start <= 1'b0;
            r_ula_op    <= 4'b0000;
            r_dado      <= '0;
            r_count     <= 8'd0;
        end else begin
            r_state     <= w_next;
            r_ready     <= w_ready;
            r_busy      <= w_busy;
            r_load_a    <= w_load_a;
            r_load_b    <= w_load_b;
            r_ula_start <= w_ula_start;
            r_ula_op    <= w_ula_op;
            r_dado      <= w_dado;
            r_count     <= w_count;
        end
    end

`ifdef ULA_TIMEOUT_EN
    logic r_erro, w_erro;

    controlador_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (w_in_wait),
        .expired (w_expired)
    );

    // erro is sticky from the abort until the next accepted instruction
    always_comb begin
        w_erro = r_erro;
        if (w_xfer) begin
            w_erro = 1'b0;
        end else if (w_in_wait && !bus.ula_done && w_expired) begin
            w_erro = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_erro <= 1'b0;
        end else begin
            r_erro <= w_erro;
        end
    end

    assign bus.erro = r_erro;
`else
    assign w_expired = 1'b0 & w_in_wait;
    assign bus.erro  = 1'b0;
`endif

    assign bus.instr_ready = r_ready;
    assign bus.busy        = r_busy;
    assign bus.load_a      = r_load_a;
    assign bus.load_b      = r_load_b;
    assign bus.ula_start   = r_ula_start;
    assign bus.ula_op      = r_ula_op;
    assign bus.dado        = r_dado;
    assign bus.op_count    = r_count;
endmodule

`default_nettype wire

// File: tb/tb_controlador_seq.sv
//==============================================================================
// tb_controlador_seq : vector table plus scoreboard of expected strobes.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_controlador_seq;
    import controlador_pkg::*;

    localparam int DATA_W  = 4;
    localparam int TIMEOUT = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    controlador_seq_if #(.DATA_W(DATA_W)) bus();

    controlador_seq #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] op;
        logic [3:0] data;
        int         dly;
    } vec_t;

    typedef struct {
        logic       la;
        logic       lb;
        logic       st;
        logic [3:0] op;
        logic [3:0] dado;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         n_cmp  = 0;
    int         n_err  = 0;
    logic [3:0] m_dado = 4'h0;
    logic [7:0] m_cnt  = 8'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] op, input logic [3:0] data);
        exp_t e;
        e.la   = (op == 4'b0000);
        e.lb   = (op == 4'b0001);
        e.st   = !(e.la || e.lb);
        e.op   = e.st ? op : 4'b0000;
        e.dado = (e.la || e.lb) ? data : m_dado;
        return e;
    endfunction

    // Every strobe cycle must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && (bus.load_a || bus.load_b || bus.ula_start)) begin
            if (sb.size() == 0) begin
                chk("spurious_strobe", {29'd0, bus.load_a, bus.load_b, bus.ula_start}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("strobe", {29'd0, bus.load_a, bus.load_b, bus.ula_start},
                    {29'd0, mon_e.la, mon_e.lb, mon_e.st});
                chk("strobe_dado", bus.dado, mon_e.dado);
                chk("strobe_ula_op", bus.ula_op, mon_e.op);
            end
        end
    end

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!bus.instr_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk("ready_timeout", bus.instr_ready, 1);
    endtask

    task automatic do_instr(input logic [3:0] op, input logic [3:0] data, input int dly);
        int nb;
        wait_ready();
        bus.instr_valid = 1'b1;
        bus.instr_op    = op;
        bus.instr_data  = data;
        sb.push_back(mk(op, data));
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("ready_after_xfer", bus.instr_ready, 0);
        chk("busy_after_xfer", bus.busy, 1);
        if (op == 4'b0000 || op == 4'b0001) begin
            m_dado = data;
            @(posedge clk); #1;
            chk("load_ready_back", bus.instr_ready, 1);
            chk("load_busy_end", bus.busy, 0);
            chk("load_strobes_off", {30'd0, bus.load_a, bus.load_b}, 0);
            chk("load_dado_hold", bus.dado, m_dado);
        end else begin
            nb = 1;
            // A competing load offered during WAIT must be ignored
            bus.instr_valid = 1'b1;
            bus.instr_op    = 4'b0000;
            bus.instr_data  = ~data;
            repeat (dly) begin
                @(posedge clk); #1;
                if (bus.busy) nb++;
                chk("ula_op_hold", bus.ula_op, op);
                chk("ula_start_once", bus.ula_start, 0);
            end
            bus.ula_done = 1'b1;
            @(posedge clk); #1;
            bus.ula_done    = 1'b0;
            bus.instr_valid = 1'b0;
            m_cnt++;
            chk("ula_busy_end", bus.busy, 0);
            chk("ula_busy_cycles", nb, dly + 1);
            chk("op_count", bus.op_count, m_cnt);
            chk("ula_op_idle", bus.ula_op, 0);
            chk("ula_dado_hold", bus.dado, m_dado);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{4'b0000, 4'hA, 0};
        vecs[1] = '{4'b0001, 4'h5, 0};
        vecs[2] = '{4'b0110, 4'h0, 4};
        vecs[3] = '{4'b0000, 4'h3, 0};
        vecs[4] = '{4'b1111, 4'h0, 1};
        vecs[5] = '{4'b0010, 4'h9, 2};
        vecs[6] = '{4'b0001, 4'hC, 0};
        vecs[7] = '{4'b0111, 4'h0, 6};

        bus.instr_valid = 1'b0;
        bus.instr_op    = 4'h0;
        bus.instr_data  = 4'h0;
        bus.ula_done    = 1'b0;

        // Reset values, and ready only after the first edge post-release
        #12;
        chk("rst_ready", bus.instr_ready, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobes", {29'd0, bus.load_a, bus.load_b, bus.ula_start}, 0);
        chk("rst_ula_op", bus.ula_op, 0);
        chk("rst_dado", bus.dado, 0);
        chk("rst_op_count", bus.op_count, 0);
        chk("rst_erro", bus.erro, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ready_before_edge", bus.instr_ready, 0);
        @(posedge clk); #1;
        chk("ready_first_edge", bus.instr_ready, 1);

        for (int i = 0; i < 8; i++) do_instr(vecs[i].op, vecs[i].data, vecs[i].dly);

        // Held valid: loads accepted on every other edge
        wait_ready();
        sb.push_back(mk(4'b0000, 4'h7));
        sb.push_back(mk(4'b0000, 4'h7));
        bus.instr_valid = 1'b1;
        bus.instr_op    = 4'b0000;
        bus.instr_data  = 4'h7;
        @(posedge clk); #1;
        chk("b2b_ready_load", bus.instr_ready, 0);
        chk("b2b_load_a_1", bus.load_a, 1);
        @(posedge clk); #1;
        chk("b2b_ready_idle", bus.instr_ready, 1);
        chk("b2b_gap", bus.load_a, 0);
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        chk("b2b_load_a_2", bus.load_a, 1);
        m_dado = 4'h7;
        @(posedge clk); #1;
        chk("b2b_done", bus.load_a, 0);
        chk("sb_empty", sb.size(), 0);

        // ula_done during EXEC is ignored
        wait_ready();
        sb.push_back(mk(4'b1001, 4'h0));
        bus.instr_valid = 1'b1;
        bus.instr_op    = 4'b1001;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        bus.ula_done    = 1'b1;
        @(posedge clk); #1;
        bus.ula_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("exec_done_ignored", bus.busy, 1);
        chk("exec_done_op", bus.ula_op, 4'b1001);
        chk("exec_done_count", bus.op_count, m_cnt);
        bus.ula_done = 1'b1;
        @(posedge clk); #1;
        bus.ula_done = 1'b0;
        m_cnt++;
        chk("exec_then_done", bus.busy, 0);
        chk("exec_then_count", bus.op_count, m_cnt);

`ifdef ULA_TIMEOUT_EN
        begin
            int nb = 0;
            int k  = 0;
            wait_ready();
            sb.push_back(mk(4'b0011, 4'h0));
            bus.instr_valid = 1'b1;
            bus.instr_op    = 4'b0011;
            @(posedge clk); #1;
            bus.instr_valid = 1'b0;
            while (bus.busy && k < 30) begin
                nb++;
                k++;
                @(posedge clk); #1;
            end
            chk("to_busy_cycles", nb, 1 + TIMEOUT);
            chk("to_erro", bus.erro, 1);
            chk("to_count", bus.op_count, m_cnt);
            chk("to_ready", bus.instr_ready, 1);
            @(posedge clk); #1;
            chk("to_erro_sticky", bus.erro, 1);
            do_instr(4'b0001, 4'h2, 0);
            chk("to_erro_cleared", bus.erro, 0);
        end
`else
        wait_ready();
        sb.push_back(mk(4'b0011, 4'h0));
        bus.instr_valid = 1'b1;
        bus.instr_op    = 4'b0011;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("nowait_busy", bus.busy, 1);
        chk("nowait_erro", bus.erro, 0);
        bus.ula_done = 1'b1;
        @(posedge clk); #1;
        bus.ula_done = 1'b0;
        m_cnt++;
        chk("nowait_count", bus.op_count, m_cnt);
`endif

        // Asynchronous reset during WAIT; late done must not count
        wait_ready();
        sb.push_back(mk(4'b0101, 4'h0));
        bus.instr_valid = 1'b1;
        bus.instr_op    = 4'b0101;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        @(posedge clk); #2;
        chk("mid_in_wait", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_ula_op", bus.ula_op, 0);
        chk("mid_rst_ready", bus.instr_ready, 0);
        chk("mid_rst_count", bus.op_count, 0);
        chk("mid_rst_dado", bus.dado, 0);
        m_cnt  = 8'd0;
        m_dado = 4'h0;
        @(negedge clk);
        rst_n        = 1'b1;
        bus.ula_done = 1'b1;
        @(posedge clk); #1;
        bus.ula_done = 1'b0;
        chk("late_done_count", bus.op_count, 0);
        chk("late_done_busy", bus.busy, 0);
        chk("late_done_ready", bus.instr_ready, 1);

        // 256 operations wrap the counter back to zero
        for (int i = 0; i < 256; i++) do_instr(4'(2 + (i % 14)), 4'h0, 1);
        chk("wrap_zero", bus.op_count, 8'd0);
        chk("sb_final_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/controlador_seq.md
CONTROLADOR_SEQ -- requirements
Module: controlador_seq

Interface
REQ-001 Parameter DATA_W, default 4: width of operand data carried with each instruction.
REQ-002 Parameter TIMEOUT, default 8: cycles waited for ula_done before abort; used only with ULA_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 instr_valid  input  1  instruction offered.
REQ-006 instr_ready  output  1  controller can accept an instruction.
REQ-007 instr_op  input  4  opcode; 4'b0000 = load A, 4'b0001 = load B, others = ULA operation.
REQ-008 instr_data  input  DATA_W  operand for load opcodes.
REQ-009 dado  output  DATA_W  operand bus to registers A/B.
REQ-010 load_a  output  1  one-cycle load strobe for register A.
REQ-011 load_b  output  1  one-cycle load strobe for register B.
REQ-012 ula_op  output  4  operation code presented to the ULA.
REQ-013 ula_start  output  1  one-cycle ULA start strobe.
REQ-014 ula_done  input  1  ULA completion, single-cycle pulse.
REQ-015 busy  output  1  high whenever state is not IDLE.
REQ-016 op_count  output  8  count of completed ULA operations.
REQ-017 erro  output  1  ULA timeout flag.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, EXEC, WAIT; all outputs SHALL be registered.
REQ-019 instr_ready SHALL be 1 only in IDLE; transfer occurs on an edge with instr_valid=1 and instr_ready=1; instr_valid is ignored otherwise.
REQ-020 On transfer, instr_op and instr_data SHALL be captured; op 0000 or 0001 -> LOAD, any other op -> EXEC.
REQ-021 LOAD SHALL last exactly one cycle (cycle after transfer) with dado = captured data and load_a (op 0000) or load_b (op 0001) high, then return to IDLE.
REQ-022 EXEC SHALL last one cycle with ula_start=1, then go to WAIT; ula_op SHALL equal the captured op throughout EXEC and WAIT and be 4'b0000 otherwise.
REQ-023 WAIT SHALL hold until ula_done=1, then return to IDLE and increment op_count by 1, wrapping 255 -> 0.
REQ-024 ula_done SHALL be ignored in IDLE, LOAD and EXEC.
REQ-025 Back-to-back: a new instruction SHALL be accepted no earlier than the first IDLE cycle; minimum spacing is 2 cycles for loads, 3 for ULA ops.
REQ-026 dado SHALL hold its last loaded value outside LOAD; load_a, load_b, ula_start SHALL be 0 outside their states.

Reset
REQ-027 While rst_n=0: state IDLE, instr_ready=0, dado=0, load_a=load_b=ula_start=0, ula_op=0, busy=0, op_count=0, erro=0.
REQ-028 instr_ready SHALL become 1 on the first clock edge after rst_n deasserts.
REQ-029 Reset asserted mid-operation SHALL abort immediately with no strobe completing and op_count cleared.

Configuration
REQ-030 Macro ULA_TIMEOUT_EN defined: a counter runs in WAIT; after TIMEOUT cycles without ula_done, FSM SHALL return to IDLE, set erro=1 without incrementing op_count; erro SHALL stay 1 until the next transfer.
REQ-031 Macro undefined: erro tied to 0, WAIT waits indefinitely, TIMEOUT unused.

Structure
REQ-032 Package controlador_pkg SHALL hold the state typedef and opcode constants OP_LOAD_A=4'b0000, OP_LOAD_B=4'b0001.
REQ-033 Timeout counter SHALL be sub-module controlador_timeout, instantiated only under ULA_TIMEOUT_EN.

Verification
REQ-034 Reset then op=0000, data=4'hA -> load_a=1, dado=4'hA for one cycle; instr_ready low that cycle, high next.
REQ-035 op=0001, data=4'h5 -> load_b=1, dado=4'h5 one cycle; load_a stays 0.
REQ-036 op=0110, ula_done 4 cycles after ula_start -> ula_start one cycle, ula_op=0110 until done, op_count 0 -> 1, busy high 5 cycles.
REQ-037 256 ULA ops with immediate done -> op_count returns to 0.
REQ-038 ULA_TIMEOUT_EN, TIMEOUT=8, no ula_done -> IDLE after 8 WAIT cycles, erro=1, op_count unchanged; next transfer clears erro.
REQ-039 rst_n low during WAIT -> all outputs 0 asynchronously; late ula_done after release ignored, op_count=0.
